ex_hazard_ctrl: RTL and testbench
=================================

// Module: ex_hazard_ctrl
// PURPOSE
//  Pipeline hazard controller for the EX stage. Generates forwarding selects for the EX operand muxes.
//  Sequences load-use stalls and multi-cycle MDU (mul/div) waits.
//  Issues IF/ID and ID/EX flushes on EX-resolved redirects (taken branch, JAL/JALR).
//  Sits beside the ID/EX, EX/MEM and MEM/WB registers and drives their stall/flush/bubble controls.
// PARAMETERS
//  LU_STALL_CYCLES  1   bubbles inserted per load-use hazard (1..7); >1 relies on write-before-read RF
//  CNT_W            32  width of performance counters (CNT_W>=2)
// PORTS
//  i_clk            in   1  clock, all state on rising edge
//  i_reset          in   1  asynchronous, active-high reset
//  i_id_rs1_addr    in   5  rs1 of instruction in ID
//  i_id_rs2_addr    in   5  rs2 of instruction in ID
//  i_id_rs1_used    in   1  ID instruction reads rs1
//  i_id_rs2_used    in   1  ID instruction reads rs2
//  i_ex_rs1_addr    in   5  rs1 of instruction in EX
//  i_ex_rs2_addr    in   5  rs2 of instruction in EX
//  i_ex_rd_addr     in   5  rd of instruction in EX
//  i_ex_rd_wren     in   1  EX instruction writes rd
//  i_ex_is_load     in   1  EX instruction is a load
//  i_ex_mdu_start   in   1  EX instruction is a multi-cycle MDU op (start pulse to MDU)
//  i_mdu_done       in   1  MDU result valid this cycle
//  i_ex_redirect    in   1  EX resolved taken branch or jump
//  i_mem_rd_addr    in   5  rd in EX/MEM
//  i_mem_rd_wren    in   1  EX/MEM writes rd
//  i_wb_rd_addr     in   5  rd in MEM/WB
//  i_wb_rd_wren     in   1  MEM/WB writes rd
//  o_forward_a_sel  out  2  00 RF, 01 WB, 10 EX/MEM, for rs1
//  o_forward_b_sel  out  2  same encoding, for rs2
//  o_pc_stall       out  1  hold PC
//  o_if_id_stall    out  1  hold IF/ID
//  o_if_id_flush    out  1  clear IF/ID to NOP
//  o_id_ex_stall    out  1  hold ID/EX
//  o_id_ex_flush    out  1  clear ID/EX to NOP
//  o_ex_mem_bubble  out  1  load NOP into EX/MEM
//  o_mdu_busy       out  1  high while in MDU_WAIT
//  o_stall_cnt      out  CNT_W  stall cycles (performance counter option only)
//  o_flush_cnt      out  CNT_W  redirect flushes (performance counter option only)
// BEHAVIOUR
//  Reset: state=RUN, lu_cnt=0, counters=0; all stall/flush/bubble/busy outputs 0; fwd sels 00.
//  Forwarding (combinational):
//   - EX/MEM match (wren, rd!=0, rd==rs) wins over WB match.
//   - x0 is never forwarded; no match gives 00.
//  FSM states RUN, LU_STALL, MDU_WAIT.
//   RUN, priority high to low:
//   1. redirect: if_id_flush=id_ex_flush=1 same cycle; stay RUN; any load-use on the ID instruction is ignored.
//   2. mdu_start & !mdu_done: stall PC, IF/ID, ID/EX; ex_mem_bubble=1; go to MDU_WAIT.
//      mdu_start & mdu_done in the same cycle: no stall.
//   3. load-use (ex_is_load, ex_rd!=0, ex_rd matches a used ID rs): stall PC+IF/ID, id_ex_flush=1.
//      LU_STALL_CYCLES==1: stay RUN. Otherwise lu_cnt<=LU_STALL_CYCLES-1 and go to LU_STALL.
//   LU_STALL: stall PC+IF/ID, id_ex_flush=1, lu_cnt decrements; when lu_cnt==1 go to RUN.
//   MDU_WAIT: o_mdu_busy=1; stall PC, IF/ID, ID/EX; ex_mem_bubble=1.
//      On i_mdu_done: release all stall/bubble outputs that cycle (result captured into EX/MEM); go to RUN.
//  Boundary cases:
//   - Stall and flush on the same register: flush wins (outputs may both be 1; register owner applies flush first).
//   - i_ex_redirect ignored outside RUN.
//   - Reset asserted mid-MDU_WAIT or mid-LU_STALL: immediate return to RUN, outputs deassert asynchronously.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined:
//   - o_stall_cnt +1 on every cycle o_pc_stall=1.
//   - o_flush_cnt +1 on every redirect.
//   - Both wrap modulo 2^CNT_W.
//  Undefined: both ports tied to 0, no counter flops.
// STRUCTURE
//  hazard_pkg:
//   - fwd_sel_e {FWD_RF=2'b00, FWD_WB=2'b01, FWD_EXMEM=2'b10}
//   - hz_state_e {RUN, LU_STALL, MDU_WAIT}
//   - REG_X0=5'd0
//  Sub-module fwd_sel_unit: combinational priority matcher, instanced once per operand.
// TESTING
//  1. ADD x5 in MEM, SUB rs1=x5 in EX, WB also rd=x5 -> fwd_a=10 (EX/MEM priority).
//  2. LW x3 in EX, ID uses rs2=x3, LU_STALL_CYCLES=1 -> one cycle pc/if_id stall + id_ex_flush.
//     Next cycle: fwd_b=01.
//  3. MDU start, done after 4 cycles -> 4 cycles of o_mdu_busy/stalls/bubble; all release in the done cycle.
//  4. Redirect coincident with load-use hazard -> flush only, no stall; o_flush_cnt +1 (macro on).
//  5. Reset pulse at MDU_WAIT cycle 2 -> outputs 0 immediately, state RUN.
//     rd=x0 writes never forward (sel 00).

Source files
------------

// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared types and constants for the EX-stage hazard controller.
package hazard_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned LU_CNT_W   = 3;

    localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_WB    = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MDU_WAIT = 2'd2
    } hz_state_e;

endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
// The pipeline side drives the master modport; the controller uses the slave modport.
interface ex_hazard_ctrl_if
    import hazard_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) ();
    logic [REG_ADDR_W-1:0] i_id_rs1_addr;
    logic [REG_ADDR_W-1:0] i_id_rs2_addr;
    logic                  i_id_rs1_used;
    logic                  i_id_rs2_used;
    logic [REG_ADDR_W-1:0] i_ex_rs1_addr;
    logic [REG_ADDR_W-1:0] i_ex_rs2_addr;
    logic [REG_ADDR_W-1:0] i_ex_rd_addr;
    logic                  i_ex_rd_wren;
    logic                  i_ex_is_load;
    logic                  i_ex_mdu_start;
    logic                  i_mdu_done;
    logic                  i_ex_redirect;
    logic [REG_ADDR_W-1:0] i_mem_rd_addr;
    logic                  i_mem_rd_wren;
    logic [REG_ADDR_W-1:0] i_wb_rd_addr;
    logic                  i_wb_rd_wren;

    logic [1:0]            o_forward_a_sel;
    logic [1:0]            o_forward_b_sel;
    logic                  o_pc_stall;
    logic                  o_if_id_stall;
    logic                  o_if_id_flush;
    logic                  o_id_ex_stall;
    logic                  o_id_ex_flush;
    logic                  o_ex_mem_bubble;
    logic                  o_mdu_busy;
    logic [CNT_W-1:0]      o_stall_cnt;
    logic [CNT_W-1:0]      o_flush_cnt;

    modport master (
        output i_id_rs1_addr, i_id_rs2_addr, i_id_rs1_used, i_id_rs2_used,
               i_ex_rs1_addr, i_ex_rs2_addr, i_ex_rd_addr, i_ex_rd_wren,
               i_ex_is_load, i_ex_mdu_start, i_mdu_done, i_ex_redirect,
               i_mem_rd_addr, i_mem_rd_wren, i_wb_rd_addr, i_wb_rd_wren,
        input  o_forward_a_sel, o_forward_b_sel, o_pc_stall, o_if_id_stall,
               o_if_id_flush, o_id_ex_stall, o_id_ex_flush, o_ex_mem_bubble,
               o_mdu_busy, o_stall_cnt, o_flush_cnt
    );

    modport slave (
        input  i_id_rs1_addr, i_id_rs2_addr, i_id_rs1_used, i_id_rs2_used,
               i_ex_rs1_addr, i_ex_rs2_addr, i_ex_rd_addr, i_ex_rd_wren,
               i_ex_is_load, i_ex_mdu_start, i_mdu_done, i_ex_redirect,
               i_mem_rd_addr, i_mem_rd_wren, i_wb_rd_addr, i_wb_rd_wren,
        output o_forward_a_sel, o_forward_b_sel, o_pc_stall, o_if_id_stall,
               o_if_id_flush, o_id_ex_stall, o_id_ex_flush, o_ex_mem_bubble,
               o_mdu_busy, o_stall_cnt, o_flush_cnt
    );

endinterface

// File: rtl/ex_hazard_ctrl_fwd.sv
// Operand forwarding select: EX/MEM result beats MEM/WB result; x0 never forwards.
module fwd_sel_unit
    import hazard_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] i_rs_addr,
    input  logic [REG_ADDR_W-1:0] i_mem_rd_addr,
    input  logic                  i_mem_rd_wren,
    input  logic [REG_ADDR_W-1:0] i_wb_rd_addr,
    input  logic                  i_wb_rd_wren,
    output fwd_sel_e              o_sel
);

    // Priority match, youngest producer first
    always_comb begin
        o_sel = FWD_RF;
        if (i_mem_rd_wren && (i_mem_rd_addr != REG_X0) && (i_mem_rd_addr == i_rs_addr)) begin
            o_sel = FWD_EXMEM;
        end else if (i_wb_rd_wren && (i_wb_rd_addr != REG_X0) && (i_wb_rd_addr == i_rs_addr)) begin
            o_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: forwarding selects, load-use and MDU stall
// sequencing, and IF/ID + ID/EX flushes on EX-resolved redirects.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module ex_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned LU_STALL_CYCLES = 1,
    parameter int unsigned CNT_W           = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    ex_hazard_ctrl_if.slave  hz
);

    hz_state_e             state_q, state_d;
    logic [LU_CNT_W-1:0]   lu_cnt_q, lu_cnt_d;

    fwd_sel_e fwd_a, fwd_b;
    logic     lu_hazard;
    logic     pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic     ex_mem_bubble, mdu_busy;

    fwd_sel_unit u_fwd_a (
        .i_rs_addr     (hz.i_ex_rs1_addr),
        .i_mem_rd_addr (hz.i_mem_rd_addr),
        .i_mem_rd_wren (hz.i_mem_rd_wren),
        .i_wb_rd_addr  (hz.i_wb_rd_addr),
        .i_wb_rd_wren  (hz.i_wb_rd_wren),
        .o_sel         (fwd_a)
    );

    fwd_sel_unit u_fwd_b (
        .i_rs_addr     (hz.i_ex_rs2_addr),
        .i_mem_rd_addr (hz.i_mem_rd_addr),
        .i_mem_rd_wren (hz.i_mem_rd_wren),
        .i_wb_rd_addr  (hz.i_wb_rd_addr),
        .i_wb_rd_wren  (hz.i_wb_rd_wren),
        .o_sel         (fwd_b)
    );

    // Load in EX produces a register a used ID source still needs
    assign lu_hazard = hz.i_ex_is_load && (hz.i_ex_rd_addr != REG_X0) &&
                       ((hz.i_id_rs1_used && (hz.i_id_rs1_addr == hz.i_ex_rd_addr)) ||
                        (hz.i_id_rs2_used && (hz.i_id_rs2_addr == hz.i_ex_rd_addr)));

    // Next-state and same-cycle stall/flush decode
    always_comb begin
        state_d       = state_q;
        lu_cnt_d      = lu_cnt_q;
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_stall   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_bubble = 1'b0;
        mdu_busy      = 1'b0;
        unique case (state_q)
            RUN: begin
                if (hz.i_ex_redirect) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (hz.i_ex_mdu_start && !hz.i_mdu_done) begin
                    pc_stall      = 1'b1;
                    if_id_stall   = 1'b1;
                    id_ex_stall   = 1'b1;
                    ex_mem_bubble = 1'b1;
                    state_d       = MDU_WAIT;
                end else if (lu_hazard) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                    if (LU_STALL_CYCLES > 1) begin
                        lu_cnt_d = LU_CNT_W'(LU_STALL_CYCLES - 1);
                        state_d  = LU_STALL;
                    end
                end
            end
            LU_STALL: begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
                lu_cnt_d    = lu_cnt_q - LU_CNT_W'(1);
                if (lu_cnt_q == LU_CNT_W'(1)) begin
                    state_d = RUN;
                end
            end
            MDU_WAIT: begin
                mdu_busy = 1'b1;
                if (hz.i_mdu_done) begin
                    state_d = RUN;
                end else begin
                    pc_stall      = 1'b1;
                    if_id_stall   = 1'b1;
                    id_ex_stall   = 1'b1;
                    ex_mem_bubble = 1'b1;
                end
            end
            default: begin
                state_d  = RUN;
                lu_cnt_d = '0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= RUN;
            lu_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            lu_cnt_q <= lu_cnt_d;
        end
    end

    // Outputs forced quiet while reset is held, independent of pipeline inputs
    assign hz.o_forward_a_sel = i_reset ? 2'(FWD_RF) : 2'(fwd_a);
    assign hz.o_forward_b_sel = i_reset ? 2'(FWD_RF) : 2'(fwd_b);
    assign hz.o_pc_stall      = pc_stall      & ~i_reset;
    assign hz.o_if_id_stall   = if_id_stall   & ~i_reset;
    assign hz.o_if_id_flush   = if_id_flush   & ~i_reset;
    assign hz.o_id_ex_stall   = id_ex_stall   & ~i_reset;
    assign hz.o_id_ex_flush   = id_ex_flush   & ~i_reset;
    assign hz.o_ex_mem_bubble = ex_mem_bubble & ~i_reset;
    assign hz.o_mdu_busy      = mdu_busy      & ~i_reset;

`ifdef HAZARD_PERF_CNT_EN
    logic             redirect_taken;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Redirects only act while running
    assign redirect_taken = (state_q == RUN) && hz.i_ex_redirect;

    // Counter increments, wrapping naturally at the counter width
    always_comb begin
        stall_cnt_d = stall_cnt_q + CNT_W'(pc_stall);
        flush_cnt_d = flush_cnt_q + CNT_W'(redirect_taken);
    end

    // Performance counter registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.o_stall_cnt = stall_cnt_q;
    assign hz.o_flush_cnt = flush_cnt_q;
`else
    assign hz.o_stall_cnt = '0;
    assign hz.o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed, table-driven bench for ex_hazard_ctrl (LU_STALL_CYCLES = 1).
// ctl vector bit order: {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
//                        id_ex_flush, ex_mem_bubble, mdu_busy}
module tb_ex_hazard_ctrl;

    logic clk;
    logic rst;

    ex_hazard_ctrl_if #(.CNT_W(32)) hz ();

    ex_hazard_ctrl #(.LU_STALL_CYCLES(1), .CNT_W(32)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .hz      (hz)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string      name;
        logic [4:0] id_rs1, id_rs2;
        logic       id_u1, id_u2;
        logic [4:0] ex_rs1, ex_rs2, ex_rd;
        logic       ex_wren, ex_load, mstart, mdone, redir;
        logic [4:0] mem_rd;
        logic       mem_wren;
        logic [4:0] wb_rd;
        logic       wb_wren;
        logic [1:0] fa, fb;
        logic [6:0] ctl;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    int n_vec;
    int n_miss;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] s0, f0;
`endif

    function automatic vec_t mk(string n, int id_rs1, int id_rs2, int id_u1, int id_u2,
                                int ex_rs1, int ex_rs2, int ex_rd, int ex_wren, int ex_load,
                                int mstart, int mdone, int redir, int mem_rd, int mem_wren,
                                int wb_rd, int wb_wren, int fa, int fb, int ctl);
        vec_t v;
        v.name     = n;
        v.id_rs1   = 5'(id_rs1);
        v.id_rs2   = 5'(id_rs2);
        v.id_u1    = 1'(id_u1);
        v.id_u2    = 1'(id_u2);
        v.ex_rs1   = 5'(ex_rs1);
        v.ex_rs2   = 5'(ex_rs2);
        v.ex_rd    = 5'(ex_rd);
        v.ex_wren  = 1'(ex_wren);
        v.ex_load  = 1'(ex_load);
        v.mstart   = 1'(mstart);
        v.mdone    = 1'(mdone);
        v.redir    = 1'(redir);
        v.mem_rd   = 5'(mem_rd);
        v.mem_wren = 1'(mem_wren);
        v.wb_rd    = 5'(wb_rd);
        v.wb_wren  = 1'(wb_wren);
        v.fa       = 2'(fa);
        v.fb       = 2'(fb);
        v.ctl      = 7'(ctl);
        return v;
    endfunction

    task automatic clear_inputs();
        hz.i_id_rs1_addr  = '0;
        hz.i_id_rs2_addr  = '0;
        hz.i_id_rs1_used  = 1'b0;
        hz.i_id_rs2_used  = 1'b0;
        hz.i_ex_rs1_addr  = '0;
        hz.i_ex_rs2_addr  = '0;
        hz.i_ex_rd_addr   = '0;
        hz.i_ex_rd_wren   = 1'b0;
        hz.i_ex_is_load   = 1'b0;
        hz.i_ex_mdu_start = 1'b0;
        hz.i_mdu_done     = 1'b0;
        hz.i_ex_redirect  = 1'b0;
        hz.i_mem_rd_addr  = '0;
        hz.i_mem_rd_wren  = 1'b0;
        hz.i_wb_rd_addr   = '0;
        hz.i_wb_rd_wren   = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        hz.i_id_rs1_addr  = v.id_rs1;
        hz.i_id_rs2_addr  = v.id_rs2;
        hz.i_id_rs1_used  = v.id_u1;
        hz.i_id_rs2_used  = v.id_u2;
        hz.i_ex_rs1_addr  = v.ex_rs1;
        hz.i_ex_rs2_addr  = v.ex_rs2;
        hz.i_ex_rd_addr   = v.ex_rd;
        hz.i_ex_rd_wren   = v.ex_wren;
        hz.i_ex_is_load   = v.ex_load;
        hz.i_ex_mdu_start = v.mstart;
        hz.i_mdu_done     = v.mdone;
        hz.i_ex_redirect  = v.redir;
        hz.i_mem_rd_addr  = v.mem_rd;
        hz.i_mem_rd_wren  = v.mem_wren;
        hz.i_wb_rd_addr   = v.wb_rd;
        hz.i_wb_rd_wren   = v.wb_wren;
    endtask

    function automatic logic [6:0] ctl_now();
        return {hz.o_pc_stall, hz.o_if_id_stall, hz.o_if_id_flush, hz.o_id_ex_stall,
                hz.o_id_ex_flush, hz.o_ex_mem_bubble, hz.o_mdu_busy};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst    = 1'b1;
        clear_inputs();

        //             name              idr1 idr2 u1 u2 exr1 exr2 exrd wr ld ms md rd memrd mw wbrd ww fa fb ctl
        vecs[0]  = mk("idle",              0,   0, 0, 0,   0,   0,   0, 0, 0, 0, 0, 0,   0, 0,   0, 0, 0, 0, 7'b0000000);
        vecs[1]  = mk("fwd_exmem_prio",    0,   0, 0, 0,   5,   6,   2, 1, 0, 0, 0, 0,   5, 1,   5, 1, 2, 0, 7'b0000000);
        vecs[2]  = mk("fwd_wb_b_mem_a",    0,   0, 0, 0,   8,   7,   0, 0, 0, 0, 0, 0,   8, 1,   7, 1, 2, 1, 7'b0000000);
        vecs[3]  = mk("fwd_x0_never",      0,   0, 0, 0,   0,   0,   0, 0, 0, 0, 0, 0,   0, 1,   0, 1, 0, 0, 7'b0000000);
        vecs[4]  = mk("fwd_no_wren",       0,   0, 0, 0,   9,   9,   0, 0, 0, 0, 0, 0,   9, 0,   9, 0, 0, 0, 7'b0000000);
        vecs[5]  = mk("fwd_wb_when_mem_off",0,  0, 0, 0,   9,  10,   0, 0, 0, 0, 0, 0,   9, 0,   9, 1, 1, 0, 7'b0000000);
        vecs[6]  = mk("load_use_rs2",      0,   3, 0, 1,   0,   0,   3, 1, 1, 0, 0, 0,   0, 0,   0, 0, 0, 0, 7'b1100100);
        vecs[7]  = mk("load_rs_unused",    3,   0, 0, 0,   0,   0,   3, 1, 1, 0, 0, 0,   0, 0,   0, 0, 0, 0, 7'b0000000);
        vecs[8]  = mk("load_rd_x0",        0,   0, 1, 1,   0,   0,   0, 1, 1, 0, 0, 0,   0, 0,   0, 0, 0, 0, 7'b0000000);
        vecs[9]  = mk("alu_not_load",      3,   0, 1, 0,   0,   0,   3, 1, 0, 0, 0, 0,   0, 0,   0, 0, 0, 0, 7'b0000000);
        vecs[10] = mk("redirect_over_lu",  3,   0, 1, 0,   0,   0,   3, 1, 1, 0, 0, 1,   0, 0,   0, 0, 0, 0, 7'b0010100);
        vecs[11] = mk("mdu_start_and_done",0,   0, 0, 0,   0,   0,   4, 1, 0, 1, 1, 0,   0, 0,   0, 0, 0, 0, 7'b0000000);
        vecs[12] = mk("redirect_over_mdu", 0,   0, 0, 0,   0,   0,   0, 0, 0, 1, 0, 1,   0, 0,   0, 0, 0, 0, 7'b0010100);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("reset_ctl",       32'(ctl_now()),          32'(7'b0000000));
        chk("reset_fwd_a",     32'(hz.o_forward_a_sel), 32'(2'b00));
        chk("reset_fwd_b",     32'(hz.o_forward_b_sel), 32'(2'b00));
        chk("reset_stall_cnt", hz.o_stall_cnt,          32'd0);
        chk("reset_flush_cnt", hz.o_flush_cnt,          32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single-cycle vectors, all leaving the FSM in RUN
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk({vecs[i].name, "_fwd_a"}, 32'(hz.o_forward_a_sel), 32'(vecs[i].fa));
            chk({vecs[i].name, "_fwd_b"}, 32'(hz.o_forward_b_sel), 32'(vecs[i].fb));
            chk({vecs[i].name, "_ctl"},   32'(ctl_now()),          32'(vecs[i].ctl));
        end

        // Load-use: stall cycle, bubble cycle, then WB forwarding to rs2
        @(negedge clk);
        clear_inputs();
        hz.i_id_rs2_addr = 5'd3; hz.i_id_rs2_used = 1'b1;
        hz.i_ex_rd_addr  = 5'd3; hz.i_ex_rd_wren  = 1'b1; hz.i_ex_is_load = 1'b1;
        #1;
        chk("lu_seq_stall", 32'(ctl_now()), 32'(7'b1100100));
        @(negedge clk);
        clear_inputs();
        hz.i_id_rs2_addr = 5'd3; hz.i_id_rs2_used = 1'b1;
        hz.i_mem_rd_addr = 5'd3; hz.i_mem_rd_wren = 1'b1;
        #1;
        chk("lu_seq_bubble_ctl", 32'(ctl_now()), 32'(7'b0000000));
        @(negedge clk);
        clear_inputs();
        hz.i_ex_rs2_addr = 5'd3;
        hz.i_wb_rd_addr  = 5'd3; hz.i_wb_rd_wren = 1'b1;
        #1;
        chk("lu_seq_fwd_b", 32'(hz.o_forward_b_sel), 32'(2'b01));
        chk("lu_seq_ctl",   32'(ctl_now()),          32'(7'b0000000));

        // MDU op: start cycle plus three wait cycles stalled, release on done
`ifdef HAZARD_PERF_CNT_EN
        s0 = hz.o_stall_cnt;
`endif
        @(negedge clk);
        clear_inputs();
        hz.i_ex_mdu_start = 1'b1;
        #1;
        chk("mdu_start_ctl", 32'(ctl_now()), 32'(7'b1101010));
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            clear_inputs();
            if (c == 2) hz.i_ex_redirect = 1'b1;
            #1;
            chk($sformatf("mdu_wait%0d_ctl", c), 32'(ctl_now()), 32'(7'b1101011));
        end
        @(negedge clk);
        clear_inputs();
        hz.i_mdu_done = 1'b1;
        #1;
        chk("mdu_done_ctl", 32'(ctl_now()), 32'(7'b0000001));
        @(negedge clk);
        clear_inputs();
        #1;
        chk("mdu_after_ctl", 32'(ctl_now()), 32'(7'b0000000));
`ifdef HAZARD_PERF_CNT_EN
        chk("mdu_stall_cnt_delta", hz.o_stall_cnt - s0, 32'd4);
`else
        chk("stall_cnt_tied_off", hz.o_stall_cnt, 32'd0);
`endif

        // Redirect coincident with load-use: flush only, counted once
`ifdef HAZARD_PERF_CNT_EN
        f0 = hz.o_flush_cnt;
`endif
        @(negedge clk);
        clear_inputs();
        hz.i_id_rs1_addr = 5'd6; hz.i_id_rs1_used = 1'b1;
        hz.i_ex_rd_addr  = 5'd6; hz.i_ex_rd_wren  = 1'b1; hz.i_ex_is_load = 1'b1;
        hz.i_ex_redirect = 1'b1;
        #1;
        chk("redir_lu_ctl", 32'(ctl_now()), 32'(7'b0010100));
        @(negedge clk);
        clear_inputs();
        #1;
        chk("redir_lu_after_ctl", 32'(ctl_now()), 32'(7'b0000000));
`ifdef HAZARD_PERF_CNT_EN
        chk("redir_flush_cnt_delta", hz.o_flush_cnt - f0, 32'd1);
`else
        chk("flush_cnt_tied_off", hz.o_flush_cnt, 32'd0);
`endif

        // Reset pulse in the middle of an MDU wait
        @(negedge clk);
        clear_inputs();
        hz.i_ex_mdu_start = 1'b1;
        #1;
        chk("rst_mdu_start_ctl", 32'(ctl_now()), 32'(7'b1101010));
        @(negedge clk);
        clear_inputs();
        #1;
        chk("rst_mdu_wait1_ctl", 32'(ctl_now()), 32'(7'b1101011));
        @(negedge clk);
        #1;
        chk("rst_mdu_wait2_ctl", 32'(ctl_now()), 32'(7'b1101011));
        rst = 1'b1;
        #1;
        chk("rst_mdu_async_ctl", 32'(ctl_now()), 32'(7'b0000000));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mdu_back_in_run", 32'(ctl_now()), 32'(7'b0000000));
        chk("rst_counter_clear",   hz.o_stall_cnt,  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
